// File: rtl/vga_grid_pkg.sv
// Shared geometry, FSM state type and cell addressing for the VGA playfield grid.
package vga_grid_pkg;

  localparam int unsigned ROWS      = 20;
  localparam int unsigned COLS      = 10;
  localparam int unsigned CELL_BITS = 10;
  localparam int unsigned GRID_W    = ROWS * COLS * CELL_BITS;

  typedef enum logic [1:0] {
    StIdle,
    StWaitVs,
    StAck
  } state_e;

  // Linear cell number; multiply by CELL_BITS for the bit offset.
  function automatic logic [31:0] cell_index(logic [4:0] row, logic [3:0] col);
    return 32'(row) * COLS + 32'(col);
  endfunction

endpackage

// File: rtl/grid_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer flips to the other requester after every grant.
module grid_rr_arbiter (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant_o  = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (enable_i) begin
      if (valid_i == 2'b11) begin
        grant_o = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant_o = valid_i;
      end
    end
    if (grant_o[0]) begin
      rr_ptr_d = 1'b1;
    end else if (grant_o[1]) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/vga_grid_scheduler.sv
// Collects cell writes from two requesters into a back buffer and copies it to the
// displayed grid only at frame start, so the picture never tears.
module vga_grid_scheduler
  import vga_grid_pkg::*;
#(
  parameter int unsigned FCNT_W = 16
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST_n,
  input  logic                 iVS,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4:0]           req0_row,
  input  logic [3:0]           req0_col,
  input  logic [CELL_BITS-1:0] req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4:0]           req1_row,
  input  logic [3:0]           req1_col,
  input  logic [CELL_BITS-1:0] req1_data,
  input  logic                 commit_req,
  output logic                 commit_ack,
  output logic [GRID_W-1:0]    grid_data,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 addr_err,
  output logic                 busy
);

  localparam logic [4:0] RowLim = 5'(ROWS);
  localparam logic [3:0] ColLim = 4'(COLS);

  state_e                state_q;
  logic                  vs_q;
  logic                  frame_start;
  logic [GRID_W-1:0]     back_q;
  logic [GRID_W-1:0]     grid_q;
  logic                  commit_ack_q;
  logic                  addr_err_q;
  logic [FCNT_W-1:0]     frame_cnt_q;

  logic [1:0]            grant;
  logic                  arb_en;
  logic                  wr_en;
  logic                  wr_in_range;
  logic [4:0]            wr_row;
  logic [3:0]            wr_col;
  logic [CELL_BITS-1:0]  wr_data;
  logic [10:0]           wr_base;

  assign frame_start = vs_q & ~iVS;
  assign arb_en      = (state_q == StIdle) & ~commit_req;

  grid_rr_arbiter u_arbiter (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .valid_i  ({req1_valid, req0_valid}),
    .enable_i (arb_en),
    .grant_o  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign wr_en       = |grant;
  assign wr_row      = grant[1] ? req1_row  : req0_row;
  assign wr_col      = grant[1] ? req1_col  : req0_col;
  assign wr_data     = grant[1] ? req1_data : req0_data;
  assign wr_in_range = (wr_row < RowLim) && (wr_col < ColLim);
  // Only meaningful when in range; the truncation never loses bits then.
  assign wr_base     = 11'(cell_index(wr_row, wr_col) * CELL_BITS);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      back_q     <= '0;
      addr_err_q <= 1'b0;
    end else if (wr_en) begin
      if (wr_in_range) begin
        back_q[wr_base +: CELL_BITS] <= wr_data;
      end else begin
        addr_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q        <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      vs_q <= iVS;
      if (frame_start) begin
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
    end
  end

  // A frame_start seen while still in StIdle is deliberately ignored: the copy
  // waits for the next full frame boundary.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= StIdle;
      grid_q       <= '0;
      commit_ack_q <= 1'b0;
    end else begin
      commit_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (commit_req) begin
            state_q <= StWaitVs;
          end
        end
        StWaitVs: begin
          if (frame_start) begin
            grid_q  <= back_q;
            state_q <= StAck;
          end
        end
        StAck: begin
          commit_ack_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grid_data  = grid_q;
  assign commit_ack = commit_ack_q;
  assign addr_err   = addr_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_vga_grid_scheduler.sv
// Directed bench for vga_grid_scheduler: stimulus pushes expected grants and commits into a
// queue, a negedge monitor pops and compares them as the DUT produces handshakes and acks.
module tb_vga_grid_scheduler;
  import vga_grid_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 vs;
  logic                 req0_valid, req0_ready;
  logic [4:0]           req0_row;
  logic [3:0]           req0_col;
  logic [9:0]           req0_data;
  logic                 req1_valid, req1_ready;
  logic [4:0]           req1_row;
  logic [3:0]           req1_col;
  logic [9:0]           req1_data;
  logic                 commit_req, commit_ack;
  logic [GRID_W-1:0]    grid_data;
  logic [15:0]          frame_cnt;
  logic                 addr_err, busy;

  always #5 clk = ~clk;

  vga_grid_scheduler dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iVS        (vs),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_row   (req0_row),
    .req0_col   (req0_col),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_row   (req1_row),
    .req1_col   (req1_col),
    .req1_data  (req1_data),
    .commit_req (commit_req),
    .commit_ack (commit_ack),
    .grid_data  (grid_data),
    .frame_cnt  (frame_cnt),
    .addr_err   (addr_err),
    .busy       (busy)
  );

  typedef struct {
    bit                is_ack;
    bit                idx;
    logic [GRID_W-1:0] grid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   acks_seen = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_grid(input string name, input logic [GRID_W-1:0] act,
                          input logic [GRID_W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      for (int k = 0; k < 200; k++) begin
        if (act[k*10 +: 10] !== exp[k*10 +: 10]) begin
          $display("FAIL %s: cell %0d got %0h expected %0h", name, k, act[k*10 +: 10],
                   exp[k*10 +: 10]);
          break;
        end
      end
    end
  endtask

  function automatic logic [GRID_W-1:0] put_cell(input logic [GRID_W-1:0] g, input int r,
                                                 input int c, input logic [9:0] d);
    g[(r * 10 + c) * 10 +: 10] = d;
    return g;
  endfunction

  task automatic push_grant(input bit idx);
    exp_t e;
    e.is_ack = 1'b0;
    e.idx    = idx;
    e.grid   = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_ack(input logic [GRID_W-1:0] g);
    exp_t e;
    e.is_ack = 1'b1;
    e.idx    = 1'b0;
    e.grid   = g;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic write1(input bit req, input logic [4:0] r, input logic [3:0] c,
                        input logic [9:0] d);
    int n = 0;
    push_grant(req);
    if (req) begin
      req1_valid = 1'b1; req1_row = r; req1_col = c; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_row = r; req0_col = c; req0_data = d;
    end
    #1;
    while (!(req ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("write_ready", {31'b0, (req ? req1_ready : req0_ready)}, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic frame();
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input int bound);
    int start = acks_seen;
    for (int n = 0; n < bound && acks_seen == start; n++) tick();
    chk("ack_arrived", acks_seen - start, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          if (exp_q.size() == 0 || exp_q[0].is_ack) begin
            n_checks++;
            $display("FAIL unexpected_grant: got req%0d expected none", req1_ready);
          end else begin
            e = exp_q.pop_front();
            chk("grant_order", {31'b0, (req1_valid && req1_ready)}, {31'b0, e.idx});
          end
        end
        if (commit_ack) begin
          acks_seen++;
          if (exp_q.size() == 0 || !exp_q[0].is_ack) begin
            n_checks++;
            $display("FAIL unexpected_ack: got ack expected none");
          end else begin
            e = exp_q.pop_front();
            chk_grid("ack_grid", grid_data, e.grid);
          end
        end
      end
    end
  end

  logic [4:0] r0s[4] = '{5'd1, 5'd19, 5'd19, 5'd5};
  logic [3:0] c0s[4] = '{4'd2, 4'd9, 4'd9, 4'd5};
  logic [9:0] d0s[4] = '{10'h111, 10'h333, 10'h333, 10'h155};
  logic [4:0] r1s[4] = '{5'd2, 5'd2, 5'd10, 5'd10};
  logic [3:0] c1s[4] = '{4'd5, 4'd5, 4'd0, 4'd0};
  logic [9:0] d1s[4] = '{10'h222, 10'h222, 10'h044, 10'h044};
  bit         gexp[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [GRID_W-1:0] g2, g3, g4, g5;
    rst_n = 1'b0; vs = 1'b1; commit_req = 1'b0;
    req0_valid = 1'b0; req0_row = '0; req0_col = '0; req0_data = '0;
    req1_valid = 1'b0; req1_row = '0; req1_col = '0; req1_data = '0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk_grid("reset_grid", grid_data, '0);
    chk("reset_frame_cnt", {16'b0, frame_cnt}, 0);
    chk("reset_addr_err", {31'b0, addr_err}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_ack", {31'b0, commit_ack}, 0);

    // Write without commit stays invisible
    write1(1'b0, 5'd0, 4'd0, 10'h3FF);
    tick();
    chk_grid("no_commit_grid", grid_data, '0);
    chk("back_cell0", {22'b0, dut.back_q[9:0]}, 32'h3FF);

    // Commit timing
    g2 = put_cell('0, 0, 0, 10'h3FF);
    push_ack(g2);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("commit_busy", {31'b0, busy}, 1);
    tick();
    chk("wait_grid_unchanged", grid_data[31:0], 0);
    vs = 1'b0;
    tick();
    chk("copy_on_frame_start", {22'b0, grid_data[9:0]}, 32'h3FF);
    chk("ack_not_yet", {31'b0, commit_ack}, 0);
    chk("busy_in_ack", {31'b0, busy}, 1);
    vs = 1'b1;
    tick();
    chk("ack_pulse", {31'b0, commit_ack}, 1);
    chk("idle_after_ack", {31'b0, busy}, 0);
    tick();
    chk("ack_one_cycle", {31'b0, commit_ack}, 0);
    chk("frame_cnt_one", {16'b0, frame_cnt}, 1);

    // Round-robin with both requesters valid
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_row = r0s[i]; req0_col = c0s[i]; req0_data = d0s[i];
      req1_valid = 1'b1; req1_row = r1s[i]; req1_col = c1s[i]; req1_data = d1s[i];
      #1;
      chk("rr_ready", {30'b0, req1_ready, req0_ready}, gexp[i] ? 32'd2 : 32'd1);
      push_grant(gexp[i]);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    g3 = put_cell('0, 1, 2, 10'h111);
    g3 = put_cell(g3, 2, 5, 10'h222);
    g3 = put_cell(g3, 19, 9, 10'h333);
    g3 = put_cell(g3, 10, 0, 10'h044);
    push_ack(g3);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    frame();
    wait_ack(10);
    chk_grid("rr_cells", grid_data, g3);

    // Out-of-range writes
    chk("addr_err_clear", {31'b0, addr_err}, 0);
    write1(1'b1, 5'd20, 4'd3, 10'h2AA);
    tick();
    chk("addr_err_row", {31'b0, addr_err}, 1);
    chk_grid("oob_no_change", dut.back_q, g3);
    write1(1'b0, 5'd0, 4'd10, 10'h0CC);
    write1(1'b0, 5'd0, 4'd1, 10'h001);
    tick();
    chk("addr_err_sticky", {31'b0, addr_err}, 1);
    g4 = put_cell(g3, 0, 1, 10'h001);
    chk_grid("back_after_oob", dut.back_q, g4);

    // Commit raised on a frame_start edge must wait for the next frame
    write1(1'b0, 5'd7, 4'd7, 10'h0AB);
    g5 = put_cell(g4, 7, 7, 10'h0AB);
    commit_req = 1'b1;
    vs = 1'b0;
    tick();
    commit_req = 1'b0;
    vs = 1'b1;
    req0_valid = 1'b1; req0_row = 5'd3; req0_col = 4'd3; req0_data = 10'h3C3;
    req1_valid = 1'b1; req1_row = 5'd4; req1_col = 4'd4; req1_data = 10'h0F0;
    chk_grid("coincident_no_copy", grid_data, g3);
    chk("coincident_busy", {31'b0, busy}, 1);
    push_ack(g5);
    for (int i = 0; i < 4; i++) begin
      chk("wait_vs_readys", {30'b0, req1_ready, req0_ready}, 0);
      tick();
    end
    vs = 1'b0;
    #1;
    chk("wait_vs_readys_fs", {30'b0, req1_ready, req0_ready}, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk_grid("second_frame_copy", grid_data, g5);
    vs = 1'b1;
    wait_ack(10);
    chk("frame_cnt_three", {16'b0, frame_cnt}, 3);

    // Frame counter wrap
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    frame();
    chk("frame_cnt_ffff", {16'b0, frame_cnt}, 32'hFFFF);
    frame();
    chk("frame_cnt_wrap", {16'b0, frame_cnt}, 0);

    // Reset while waiting for VS drops the commit
    write1(1'b0, 5'd4, 4'd4, 10'h1F0);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("pre_reset_busy", {31'b0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state_idle", {31'b0, busy}, 0);
    chk_grid("rst_grid", grid_data, '0);
    chk("rst_frame_cnt", {16'b0, frame_cnt}, 0);
    chk("rst_addr_err", {31'b0, addr_err}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame();
    for (int i = 0; i < 3; i++) begin
      chk("no_ack_after_rst", {31'b0, commit_ack}, 0);
      tick();
    end
    chk_grid("rst_grid_stays", grid_data, '0);
    chk_grid("rst_back", dut.back_q, '0);

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
